// File: rtl/reservation_station_if.sv
// Dispatch, wakeup and issue bus between the rename/dispatch stage, the result broadcast
// and the reservation station feeding one FunctionalUnit.
interface reservation_station_if #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned TAG_W = 6,
    parameter int unsigned ROB_W = 6
);
    localparam int unsigned OCC_W = $clog2(DEPTH) + 1;

    logic             dispatch_valid;
    logic             dispatch_ready;
    logic [3:0]       d_ALUControl;
    logic             d_ALUSrc;
    logic             d_is_for_lsq;
    logic [31:0]      d_imm;
    logic             d_rs1_ready;
    logic             d_rs2_ready;
    logic [TAG_W-1:0] d_rs1_tag;
    logic [TAG_W-1:0] d_rs2_tag;
    logic [31:0]      d_rs1_value;
    logic [31:0]      d_rs2_value;
    logic [TAG_W-1:0] d_tag_to_output;
    logic [ROB_W-1:0] d_rob_index;

    logic             wakeup_active;
    logic [TAG_W-1:0] wakeup_tag;
    logic [31:0]      wakeup_value;

    logic             fu_available;
    logic             issue_valid;
    logic [3:0]       issue_ALUControl;
    logic             issue_ALUSrc;
    logic             issue_is_for_lsq;
    logic [31:0]      issue_imm;
    logic [31:0]      issue_rs1_value;
    logic [31:0]      issue_rs2_value;
    logic [TAG_W-1:0] issue_tag_to_output;
    logic [ROB_W-1:0] issue_rob_index;

    logic [OCC_W-1:0] occupancy;

    modport master (
        output dispatch_valid, d_ALUControl, d_ALUSrc, d_is_for_lsq, d_imm,
               d_rs1_ready, d_rs2_ready, d_rs1_tag, d_rs2_tag, d_rs1_value, d_rs2_value,
               d_tag_to_output, d_rob_index, wakeup_active, wakeup_tag, wakeup_value,
               fu_available,
        input  dispatch_ready, issue_valid, issue_ALUControl, issue_ALUSrc, issue_is_for_lsq,
               issue_imm, issue_rs1_value, issue_rs2_value, issue_tag_to_output,
               issue_rob_index, occupancy
    );

    modport slave (
        input  dispatch_valid, d_ALUControl, d_ALUSrc, d_is_for_lsq, d_imm,
               d_rs1_ready, d_rs2_ready, d_rs1_tag, d_rs2_tag, d_rs1_value, d_rs2_value,
               d_tag_to_output, d_rob_index, wakeup_active, wakeup_tag, wakeup_value,
               fu_available,
        output dispatch_ready, issue_valid, issue_ALUControl, issue_ALUSrc, issue_is_for_lsq,
               issue_imm, issue_rs1_value, issue_rs2_value, issue_tag_to_output,
               issue_rob_index, occupancy
    );
endinterface

// File: rtl/reservation_station.sv
// Issue queue: holds renamed instructions until operands are captured from the wakeup bus,
// then issues the lowest-index ready entry to the FunctionalUnit each cycle.
module reservation_station #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned TAG_W = 6,
    parameter int unsigned ROB_W = 6
) (
    input logic                  clk,
    input logic                  reset,
    reservation_station_if.slave bus
);
    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned OCC_W = $clog2(DEPTH) + 1;

    logic [DEPTH-1:0] valid_q, valid_d;
    logic [DEPTH-1:0] r1rdy_q, r1rdy_d;
    logic [DEPTH-1:0] r2rdy_q, r2rdy_d;
    logic [DEPTH-1:0] src_q, src_d;
    logic [DEPTH-1:0] lsq_q, lsq_d;
    logic [3:0]       op_q    [DEPTH];
    logic [3:0]       op_d    [DEPTH];
    logic [31:0]      imm_q   [DEPTH];
    logic [31:0]      imm_d   [DEPTH];
    logic [TAG_W-1:0] r1tag_q [DEPTH];
    logic [TAG_W-1:0] r1tag_d [DEPTH];
    logic [TAG_W-1:0] r2tag_q [DEPTH];
    logic [TAG_W-1:0] r2tag_d [DEPTH];
    logic [31:0]      r1val_q [DEPTH];
    logic [31:0]      r1val_d [DEPTH];
    logic [31:0]      r2val_q [DEPTH];
    logic [31:0]      r2val_d [DEPTH];
    logic [TAG_W-1:0] dtag_q  [DEPTH];
    logic [TAG_W-1:0] dtag_d  [DEPTH];
    logic [ROB_W-1:0] rob_q   [DEPTH];
    logic [ROB_W-1:0] rob_d   [DEPTH];
    logic [OCC_W-1:0] occ_q, occ_d;

    logic [DEPTH-1:0] entry_rdy;
    logic             iss_any;
    logic [IDX_W-1:0] iss_idx;
    logic [IDX_W-1:0] free_idx;
    logic             issue_fire;
    logic             disp_ready;
    logic             disp_fire;
    logic             r1_hit;
    logic             r2_hit;

    // Readiness and priority selects are all taken from pre-edge state.
    always_comb begin
        iss_any  = 1'b0;
        iss_idx  = '0;
        free_idx = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            entry_rdy[i] = valid_q[i] &&
                           ((op_q[i] == 4'd0) || (r1rdy_q[i] && (r2rdy_q[i] || src_q[i])));
        end
        for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
            if (entry_rdy[i]) begin
                iss_any = 1'b1;
                iss_idx = IDX_W'(i);
            end
            if (!valid_q[i]) begin
                free_idx = IDX_W'(i);
            end
        end
    end

    // Nothing issues while reset is asserted, so the FU never latches a discarded entry.
    assign issue_fire = reset && bus.fu_available && iss_any;
    assign disp_ready = (occ_q < OCC_W'(DEPTH));
    assign disp_fire  = bus.dispatch_valid && disp_ready;
    assign r1_hit     = bus.wakeup_active && !bus.d_rs1_ready && (bus.d_rs1_tag == bus.wakeup_tag);
    assign r2_hit     = bus.wakeup_active && !bus.d_rs2_ready && (bus.d_rs2_tag == bus.wakeup_tag);

    always_comb begin
        valid_d = valid_q;
        r1rdy_d = r1rdy_q;
        r2rdy_d = r2rdy_q;
        src_d   = src_q;
        lsq_d   = lsq_q;
        op_d    = op_q;
        imm_d   = imm_q;
        r1tag_d = r1tag_q;
        r2tag_d = r2tag_q;
        r1val_d = r1val_q;
        r2val_d = r2val_q;
        dtag_d  = dtag_q;
        rob_d   = rob_q;

        if (bus.wakeup_active) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                if (valid_q[i] && !r1rdy_q[i] && (r1tag_q[i] == bus.wakeup_tag)) begin
                    r1rdy_d[i] = 1'b1;
                    r1val_d[i] = bus.wakeup_value;
                end
                if (valid_q[i] && !r2rdy_q[i] && (r2tag_q[i] == bus.wakeup_tag)) begin
                    r2rdy_d[i] = 1'b1;
                    r2val_d[i] = bus.wakeup_value;
                end
            end
        end

        if (issue_fire) begin
            valid_d[iss_idx] = 1'b0;
        end

        // free_idx is a pre-edge free slot, so it never collides with the issuing slot.
        if (disp_fire) begin
            valid_d[free_idx] = 1'b1;
            op_d[free_idx]    = bus.d_ALUControl;
            src_d[free_idx]   = bus.d_ALUSrc;
            lsq_d[free_idx]   = bus.d_is_for_lsq;
            imm_d[free_idx]   = bus.d_imm;
            r1tag_d[free_idx] = bus.d_rs1_tag;
            r2tag_d[free_idx] = bus.d_rs2_tag;
            r1rdy_d[free_idx] = bus.d_rs1_ready || r1_hit;
            r2rdy_d[free_idx] = bus.d_rs2_ready || r2_hit;
            r1val_d[free_idx] = r1_hit ? bus.wakeup_value : bus.d_rs1_value;
            r2val_d[free_idx] = r2_hit ? bus.wakeup_value : bus.d_rs2_value;
            dtag_d[free_idx]  = bus.d_tag_to_output;
            rob_d[free_idx]   = bus.d_rob_index;
        end

        occ_d = occ_q + OCC_W'(disp_fire) - OCC_W'(issue_fire);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            valid_q <= '0;
            occ_q   <= '0;
        end else begin
            valid_q <= valid_d;
            occ_q   <= occ_d;
        end
    end

    // Payload is qualified by valid_q, so it needs no reset.
    always_ff @(posedge clk) begin
        r1rdy_q <= r1rdy_d;
        r2rdy_q <= r2rdy_d;
        src_q   <= src_d;
        lsq_q   <= lsq_d;
        op_q    <= op_d;
        imm_q   <= imm_d;
        r1tag_q <= r1tag_d;
        r2tag_q <= r2tag_d;
        r1val_q <= r1val_d;
        r2val_q <= r2val_d;
        dtag_q  <= dtag_d;
        rob_q   <= rob_d;
    end

    assign bus.dispatch_ready      = disp_ready;
    assign bus.occupancy           = occ_q;
    assign bus.issue_valid         = issue_fire;
    assign bus.issue_ALUControl    = issue_fire ? op_q[iss_idx]    : '0;
    assign bus.issue_ALUSrc        = issue_fire ? src_q[iss_idx]   : 1'b0;
    assign bus.issue_is_for_lsq    = issue_fire ? lsq_q[iss_idx]   : 1'b0;
    assign bus.issue_imm           = issue_fire ? imm_q[iss_idx]   : '0;
    assign bus.issue_rs1_value     = issue_fire ? r1val_q[iss_idx] : '0;
    assign bus.issue_rs2_value     = issue_fire ? r2val_q[iss_idx] : '0;
    assign bus.issue_tag_to_output = issue_fire ? dtag_q[iss_idx]  : '0;
    assign bus.issue_rob_index     = issue_fire ? rob_q[iss_idx]   : '0;
endmodule

// File: tb/tb_reservation_station.sv
// Self-checking bench: streamed vector table with a scoreboard, plus hand-written
// sequences for wakeup, full queue, issue priority and mid-run reset.
module tb_reservation_station;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned TAG_W = 6;
    localparam int unsigned ROB_W = 6;
    localparam int NV = 6;

    typedef struct {
        logic [3:0]  op;
        logic        src;
        logic        lsq;
        logic [31:0] imm;
        logic        r1rdy;
        logic [5:0]  r1tag;
        logic [31:0] r1val;
        logic        r2rdy;
        logic [5:0]  r2tag;
        logic [31:0] r2val;
        logic [5:0]  dtag;
        logic [5:0]  rob;
        logic        wk;
        logic [5:0]  wktag;
        logic [31:0] wkval;
        logic [31:0] exp_rs1;
        logic [31:0] exp_rs2;
    } vec_t;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;
    vec_t vecs [NV];
    vec_t sb[$];
    vec_t e;

    reservation_station_if #(.DEPTH(DEPTH), .TAG_W(TAG_W), .ROB_W(ROB_W)) bus ();

    reservation_station #(.DEPTH(DEPTH), .TAG_W(TAG_W), .ROB_W(ROB_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle();
        bus.dispatch_valid  = 1'b0;
        bus.d_ALUControl    = 4'd0;
        bus.d_ALUSrc        = 1'b0;
        bus.d_is_for_lsq    = 1'b0;
        bus.d_imm           = 32'd0;
        bus.d_rs1_ready     = 1'b0;
        bus.d_rs2_ready     = 1'b0;
        bus.d_rs1_tag       = 6'd0;
        bus.d_rs2_tag       = 6'd0;
        bus.d_rs1_value     = 32'd0;
        bus.d_rs2_value     = 32'd0;
        bus.d_tag_to_output = 6'd0;
        bus.d_rob_index     = 6'd0;
        bus.wakeup_active   = 1'b0;
        bus.wakeup_tag      = 6'd0;
        bus.wakeup_value    = 32'd0;
    endtask

    task automatic drive_vec(input vec_t v);
        bus.dispatch_valid  = 1'b1;
        bus.d_ALUControl    = v.op;
        bus.d_ALUSrc        = v.src;
        bus.d_is_for_lsq    = v.lsq;
        bus.d_imm           = v.imm;
        bus.d_rs1_ready     = v.r1rdy;
        bus.d_rs1_tag       = v.r1tag;
        bus.d_rs1_value     = v.r1val;
        bus.d_rs2_ready     = v.r2rdy;
        bus.d_rs2_tag       = v.r2tag;
        bus.d_rs2_value     = v.r2val;
        bus.d_tag_to_output = v.dtag;
        bus.d_rob_index     = v.rob;
        bus.wakeup_active   = v.wk;
        bus.wakeup_tag      = v.wktag;
        bus.wakeup_value    = v.wkval;
    endtask

    task automatic disp(input logic [3:0] op, input logic r1rdy, input logic [5:0] r1tag,
                        input logic [31:0] r1val, input logic r2rdy, input logic [5:0] r2tag,
                        input logic [31:0] r2val);
        idle();
        bus.dispatch_valid  = 1'b1;
        bus.d_ALUControl    = op;
        bus.d_rs1_ready     = r1rdy;
        bus.d_rs1_tag       = r1tag;
        bus.d_rs1_value     = r1val;
        bus.d_rs2_ready     = r2rdy;
        bus.d_rs2_tag       = r2tag;
        bus.d_rs2_value     = r2val;
        bus.d_tag_to_output = 6'd1;
        bus.d_rob_index     = 6'd1;
    endtask

    task automatic next_edge();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        //          op    src   lsq   imm          r1rdy r1tag r1val         r2rdy r2tag r2val
        //          dtag  rob   wk    wktag wkval        exp_rs1       exp_rs2
        vecs[0] = '{4'd2, 1'b0, 1'b0, 32'd0,       1'b1, 6'd0, 32'd2,        1'b1, 6'd0, 32'd3,
                    6'd4, 6'd3, 1'b0, 6'd0, 32'd0,        32'd2,        32'd3};
        vecs[1] = '{4'd6, 1'b0, 1'b0, 32'd0,       1'b1, 6'd0, 32'hFFFFFFFF, 1'b1, 6'd0, 32'd5,
                    6'd9, 6'd10, 1'b0, 6'd0, 32'd0,       32'hFFFFFFFF, 32'd5};
        vecs[2] = '{4'd2, 1'b0, 1'b0, 32'd0,       1'b1, 6'd0, 32'd8,        1'b0, 6'd5, 32'd0,
                    6'd11, 6'd4, 1'b1, 6'd5, 32'd42,      32'd8,        32'd42};
        vecs[3] = '{4'd3, 1'b0, 1'b0, 32'd0,       1'b0, 6'd0, 32'd0,        1'b1, 6'd0, 32'd7,
                    6'd12, 6'd5, 1'b1, 6'd0, 32'h1234,    32'h1234,     32'd7};
        vecs[4] = '{4'd2, 1'b1, 1'b1, 32'h80,      1'b1, 6'd0, 32'hA5,       1'b1, 6'd0, 32'd0,
                    6'd13, 6'd6, 1'b0, 6'd0, 32'd0,       32'hA5,       32'd0};
        vecs[5] = '{4'd4, 1'b0, 1'b0, 32'd0,       1'b1, 6'd0, 32'd3,        1'b1, 6'd0, 32'd4,
                    6'd14, 6'd7, 1'b1, 6'd33, 32'd99,     32'd3,        32'd4};

        idle();
        bus.fu_available = 1'b0;
        reset = 1'b0;
        next_edge();
        next_edge();
        @(negedge clk);
        check("reset_issue_valid", {31'd0, bus.issue_valid}, 32'd0);
        check("reset_occupancy", 32'(bus.occupancy), 32'd0);
        check("reset_dispatch_ready", {31'd0, bus.dispatch_ready}, 32'd1);
        check("reset_payload_zero", bus.issue_rs1_value, 32'd0);
        next_edge();
        reset = 1'b1;

        // Streamed table: each entry is dispatched while the previous one issues.
        bus.fu_available = 1'b1;
        for (int k = 0; k <= NV; k++) begin
            if (k < NV) begin
                drive_vec(vecs[k]);
                sb.push_back(vecs[k]);
            end else begin
                idle();
            end
            @(negedge clk);
            if (k == 0) begin
                check("stream_first_no_issue", {31'd0, bus.issue_valid}, 32'd0);
            end else begin
                check("stream_issue_valid", {31'd0, bus.issue_valid}, 32'd1);
                check("stream_occupancy", 32'(bus.occupancy), 32'd1);
                if (bus.issue_valid && sb.size() > 0) begin
                    e = sb.pop_front();
                    check("stream_op", 32'(bus.issue_ALUControl), 32'(e.op));
                    check("stream_src", {31'd0, bus.issue_ALUSrc}, {31'd0, e.src});
                    check("stream_lsq", {31'd0, bus.issue_is_for_lsq}, {31'd0, e.lsq});
                    check("stream_imm", bus.issue_imm, e.imm);
                    check("stream_rs1", bus.issue_rs1_value, e.exp_rs1);
                    check("stream_rs2", bus.issue_rs2_value, e.exp_rs2);
                    check("stream_tag", 32'(bus.issue_tag_to_output), 32'(e.dtag));
                    check("stream_rob", 32'(bus.issue_rob_index), 32'(e.rob));
                end
            end
            next_edge();
        end
        @(negedge clk);
        check("stream_sb_empty", 32'(sb.size()), 32'd0);
        check("stream_occ_end", 32'(bus.occupancy), 32'd0);

        // Wakeup capture: no issue while waiting or in the capture cycle itself.
        next_edge();
        disp(4'd2, 1'b0, 6'd7, 32'd0, 1'b1, 6'd0, 32'd1);
        next_edge();
        idle();
        @(negedge clk);
        check("wait_no_issue", {31'd0, bus.issue_valid}, 32'd0);
        next_edge();
        bus.wakeup_active = 1'b1;
        bus.wakeup_tag    = 6'd7;
        bus.wakeup_value  = 32'd10;
        @(negedge clk);
        check("wake_same_cycle", {31'd0, bus.issue_valid}, 32'd0);
        next_edge();
        idle();
        @(negedge clk);
        check("wake_issue_valid", {31'd0, bus.issue_valid}, 32'd1);
        check("wake_rs1", bus.issue_rs1_value, 32'd10);
        check("wake_rs2", bus.issue_rs2_value, 32'd1);
        next_edge();

        // One broadcast satisfies both operands.
        disp(4'd2, 1'b0, 6'd12, 32'd0, 1'b0, 6'd12, 32'd0);
        next_edge();
        idle();
        bus.wakeup_active = 1'b1;
        bus.wakeup_tag    = 6'd12;
        bus.wakeup_value  = 32'd77;
        next_edge();
        idle();
        @(negedge clk);
        check("both_issue_valid", {31'd0, bus.issue_valid}, 32'd1);
        check("both_rs1", bus.issue_rs1_value, 32'd77);
        check("both_rs2", bus.issue_rs2_value, 32'd77);
        next_edge();

        // Immediate form ignores rs2; NOP ignores both operands.
        disp(4'd2, 1'b1, 6'd0, 32'd9, 1'b0, 6'd40, 32'd0);
        bus.d_ALUSrc = 1'b1;
        bus.d_imm    = 32'h80;
        next_edge();
        idle();
        @(negedge clk);
        check("alusrc_issue_valid", {31'd0, bus.issue_valid}, 32'd1);
        check("alusrc_imm", bus.issue_imm, 32'h80);
        next_edge();
        disp(4'd0, 1'b0, 6'd41, 32'd0, 1'b0, 6'd42, 32'd0);
        next_edge();
        idle();
        @(negedge clk);
        check("nop_issue_valid", {31'd0, bus.issue_valid}, 32'd1);
        check("nop_op", 32'(bus.issue_ALUControl), 32'd0);
        next_edge();
        @(negedge clk);
        check("nop_occ", 32'(bus.occupancy), 32'd0);
        next_edge();

        // Full queue: ninth dispatch ignored, freed slot not reusable in the issue edge.
        bus.fu_available = 1'b0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            disp(4'd2, 1'b1, 6'd0, 32'(100 + i), 1'b1, 6'd0, 32'd0);
            next_edge();
        end
        disp(4'd2, 1'b1, 6'd0, 32'd999, 1'b1, 6'd0, 32'd0);
        @(negedge clk);
        check("full_dispatch_ready", {31'd0, bus.dispatch_ready}, 32'd0);
        check("full_occupancy", 32'(bus.occupancy), 32'd8);
        check("full_no_issue", {31'd0, bus.issue_valid}, 32'd0);
        next_edge();
        @(negedge clk);
        check("full_ignored_occ", 32'(bus.occupancy), 32'd8);
        next_edge();
        bus.fu_available = 1'b1;
        @(negedge clk);
        check("full_issue_slot0", bus.issue_rs1_value, 32'd100);
        next_edge();
        bus.fu_available = 1'b0;
        idle();
        @(negedge clk);
        check("after_issue_occ", 32'(bus.occupancy), 32'd7);
        check("after_issue_ready", {31'd0, bus.dispatch_ready}, 32'd1);
        disp(4'd2, 1'b1, 6'd0, 32'd555, 1'b1, 6'd0, 32'd0);
        next_edge();
        idle();
        bus.fu_available = 1'b1;
        for (int j = 0; j < int'(DEPTH); j++) begin
            @(negedge clk);
            check("drain_valid", {31'd0, bus.issue_valid}, 32'd1);
            check("drain_rs1", bus.issue_rs1_value, (j == 0) ? 32'd555 : 32'(100 + j));
            next_edge();
        end
        @(negedge clk);
        check("drain_occ", 32'(bus.occupancy), 32'd0);
        next_edge();

        // Lowest-index ready entry wins; slot 1 waits on tag 20.
        bus.fu_available = 1'b0;
        disp(4'd2, 1'b1, 6'd0, 32'd11, 1'b1, 6'd0, 32'd0);
        next_edge();
        disp(4'd2, 1'b0, 6'd20, 32'd0, 1'b1, 6'd0, 32'd0);
        next_edge();
        disp(4'd2, 1'b1, 6'd0, 32'd33, 1'b1, 6'd0, 32'd0);
        next_edge();
        idle();
        bus.fu_available = 1'b1;
        @(negedge clk);
        check("prio_first", bus.issue_rs1_value, 32'd11);
        next_edge();
        @(negedge clk);
        check("prio_second", bus.issue_rs1_value, 32'd33);
        next_edge();
        @(negedge clk);
        check("prio_blocked", {31'd0, bus.issue_valid}, 32'd0);
        check("prio_occ", 32'(bus.occupancy), 32'd1);

        // Mid-run reset with three live entries.
        next_edge();
        bus.fu_available = 1'b0;
        disp(4'd2, 1'b1, 6'd0, 32'd44, 1'b1, 6'd0, 32'd0);
        next_edge();
        disp(4'd2, 1'b1, 6'd0, 32'd45, 1'b1, 6'd0, 32'd0);
        next_edge();
        idle();
        @(negedge clk);
        check("pre_reset_occ", 32'(bus.occupancy), 32'd3);
        next_edge();
        reset = 1'b0;
        bus.fu_available = 1'b1;
        @(negedge clk);
        check("in_reset_no_issue", {31'd0, bus.issue_valid}, 32'd0);
        next_edge();
        reset = 1'b1;
        @(negedge clk);
        check("post_reset_occ", 32'(bus.occupancy), 32'd0);
        check("post_reset_ready", {31'd0, bus.dispatch_ready}, 32'd1);
        check("post_reset_no_issue", {31'd0, bus.issue_valid}, 32'd0);
        check("post_reset_payload", bus.issue_rs1_value, 32'd0);
        next_edge();
        bus.wakeup_active = 1'b1;
        bus.wakeup_tag    = 6'd20;
        bus.wakeup_value  = 32'd5;
        next_edge();
        idle();
        @(negedge clk);
        check("no_stale_issue", {31'd0, bus.issue_valid}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
